// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Top-level game-flow FSM. It sequences one level at a time through
//   IDLE -> GEN -> PLAY -> RESULT -> SHOP -> GEN ... and ends in OVER or WIN.
//   It accumulates scoreIncrease into a saturating running score and judges
//   pass/fail of each level against a per-level target score.
//
//   Pulse-input semantics: startBtn, oneSecPulse, genDone, stageEnded and
//   shopDone are single-cycle strobes. A strobe is consumed on the clock edge
//   where it is high, and only if the current state listens for it. Otherwise
//   it is dropped. Nothing is buffered. stagePassed is qualified by
//   stageEnded. scoreIncrease is a per-cycle amount that is summed only in
//   PLAY.
//
// Optional feature (macro STAGE_SEQ_PAUSE_EN):
//   This adds pauseBtn (in) and secPulseOut (out). In PLAY, pauseBtn toggles
//   a pause flag, and secPulseOut is a registered copy of oneSecPulse that is
//   gated by that flag. levelEnable is not affected by pause.
//
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   startBtn           start / restart strobe
//   oneSecPulse        one strobe per second
//   genDone            level generator finished
//   stageEnded         level over; stagePassed is valid with it
//   scoreIncrease[20]  points to add this cycle
//   shopDone           player left the shop
//   levelEnable        high only in PLAY (its rising edge starts a level)
//   generateLevel      1-cycle strobe on entry to GEN
//   levelIndex[4]      current level
//   score[20]          accumulated score, saturating at 20'hFFFFF
//   targetScore[20]    TARGET_BASE + levelIndex*TARGET_STEP
//   shopEnable         high only in SHOP
//   gameOver, gameWon  high in OVER / WIN
//   state[3]           FSM state: IDLE=0 GEN=1 PLAY=2 RESULT=3 SHOP=4 OVER=5 WIN=6
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter int          MAX_LEVEL   = 3,
  parameter logic [19:0] TARGET_BASE = 20'd100,
  parameter logic [19:0] TARGET_STEP = 20'd150,
  parameter int          RESULT_SECS = 3,
  parameter int          GEN_TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startBtn,
  input  logic        oneSecPulse,
  input  logic        genDone,
  input  logic        stageEnded,
  input  logic        stagePassed,
  input  logic [19:0] scoreIncrease,
  input  logic        shopDone,
`ifdef STAGE_SEQ_PAUSE_EN
  input  logic        pauseBtn,
  output logic        secPulseOut,
`endif
  output logic        levelEnable,
  output logic        generateLevel,
  output logic [3:0]  levelIndex,
  output logic [19:0] score,
  output logic [19:0] targetScore,
  output logic        shopEnable,
  output logic        gameOver,
  output logic        gameWon,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_PLAY   = 3'd2,
    S_RESULT = 3'd3,
    S_SHOP   = 3'd4,
    S_OVER   = 3'd5,
    S_WIN    = 3'd6
  } stateT;

  localparam int GCW = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT) : 1;
  localparam int SCW = (RESULT_SECS > 1) ? $clog2(RESULT_SECS) : 1;

  stateT          stateQ;
  stateT          stateD;
  logic [GCW-1:0] genCnt;
  logic [SCW-1:0] secCnt;
  logic           passFlag;

  logic           levelEnableD;
  logic           generateLevelD;
  logic           shopEnableD;
  logic           gameOverD;
  logic           gameWonD;

  // A 21-bit sum catches the carry. On overflow the score clamps to all-ones.
  logic [20:0]    scoreSum;
  logic [19:0]    scoreNext;
  logic           genTimeout;
  logic           resultDone;
  logic           lastLevel;

  assign scoreSum   = {1'b0, score} + {1'b0, scoreIncrease};
  assign scoreNext  = scoreSum[20] ? 20'hFFFFF : scoreSum[19:0];
  assign genTimeout = (genCnt == GCW'(GEN_TIMEOUT - 1));
  assign resultDone = oneSecPulse && (secCnt == SCW'(RESULT_SECS - 1));
  assign lastLevel  = (levelIndex == 4'(MAX_LEVEL - 1));
  assign state      = stateQ;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) stateQ <= S_IDLE;
    else         stateQ <= stateD;
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE:   if (startBtn) stateD = S_GEN;
      // genDone takes priority, so a genDone on the last counted cycle still wins.
      S_GEN: begin
        if (genDone)         stateD = S_PLAY;
        else if (genTimeout) stateD = S_OVER;
      end
      S_PLAY:   if (stageEnded) stateD = S_RESULT;
      S_RESULT: begin
        if (resultDone) begin
          if (!passFlag)      stateD = S_OVER;
          else if (lastLevel) stateD = S_WIN;
          else                stateD = S_SHOP;
        end
      end
      S_SHOP:         if (shopDone) stateD = S_GEN;
      S_OVER, S_WIN:  if (startBtn) stateD = S_IDLE;
      default:        stateD = S_IDLE;
    endcase
  end

  // Output decode. It looks at the next state so that the registered
  // outputs line up with the state register.
  always_comb begin
    levelEnableD   = (stateD == S_PLAY);
    generateLevelD = (stateD == S_GEN) && (stateQ != S_GEN);
    shopEnableD    = (stateD == S_SHOP);
    gameOverD      = (stateD == S_OVER);
    gameWonD       = (stateD == S_WIN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      levelEnable   <= 1'b0;
      generateLevel <= 1'b0;
      shopEnable    <= 1'b0;
      gameOver      <= 1'b0;
      gameWon       <= 1'b0;
    end else begin
      levelEnable   <= levelEnableD;
      generateLevel <= generateLevelD;
      shopEnable    <= shopEnableD;
      gameOver      <= gameOverD;
      gameWon       <= gameWonD;
    end
  end

  // Datapath: counters, score, level and target.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      genCnt      <= '0;
      secCnt      <= '0;
      passFlag    <= 1'b0;
      score       <= '0;
      levelIndex  <= '0;
      targetScore <= TARGET_BASE;
    end else begin
      // Both counters sit at zero outside their own state, so they start
      // from zero on every entry.
      genCnt <= (stateQ == S_GEN) ? genCnt + GCW'(1) : '0;
      if (stateQ != S_RESULT)  secCnt <= '0;
      else if (oneSecPulse)    secCnt <= secCnt + SCW'(1);

      case (stateQ)
        S_IDLE: begin
          score       <= '0;
          levelIndex  <= '0;
          targetScore <= TARGET_BASE;
        end
        S_PLAY: begin
          score <= scoreNext;
          // Judge against scoreNext so that points arriving with stageEnded count.
          if (stageEnded) passFlag <= stagePassed | (scoreNext >= targetScore);
        end
        S_SHOP: begin
          if (shopDone) begin
            levelIndex  <= levelIndex + 4'd1;
            targetScore <= targetScore + TARGET_STEP;
          end
        end
        S_OVER, S_WIN: begin
          if (startBtn) begin
            score       <= '0;
            levelIndex  <= '0;
            targetScore <= TARGET_BASE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STAGE_SEQ_PAUSE_EN
  logic paused;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      paused      <= 1'b0;
      secPulseOut <= 1'b0;
    end else begin
      if (stateD != S_PLAY)                   paused <= 1'b0;
      else if (stateQ == S_PLAY && pauseBtn)  paused <= !paused;
      secPulseOut <= oneSecPulse & !paused;
    end
  end
`endif

endmodule
